uart_rx_fifo: RTL and testbench

Serial receive front end for the FM synthesizer's MIDI input. The block oversamples an asynchronous 8N1 serial line, assembles bytes, and pushes them into an 8-bit-wide FIFO. The AXI-Lite register wrapper pops bytes from the FIFO and uses the not-empty flag as its interrupt.

---
 rtl/uart_rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// MIDI serial receiver: 2-flop synchronizer, 8N1 oversampling FSM, and a
// first-word-fall-through byte FIFO whose not-empty flag serves as the interrupt.
module uart_rx_fifo #(
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned CLK_FREQ   = 32653031,
  parameter int unsigned BAUD_RATE  = 31250,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_data,
  input  logic                          rd_en,
  output logic [7:0]                    word_out,
  output logic                          word_rdy,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level
  // START  | timing to mid start bit, rejecting glitches
  // DATA   | sampling 8 data bits at mid-bit
  // STOP   | sampling the stop bit, then strobing result

  localparam int unsigned CPB  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int          CW   = $clog2(CPB);
  localparam int          AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    rx_data_nxt;
  logic          rx_valid_nxt, frame_err_nxt;
  logic          rx_meta, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_data;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // cnt is a down-counter; every sample point is its terminal count of zero
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = CNT_HALF;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            cnt_nxt     = CNT_BIT;
            bit_idx_nxt = '0;
            state_nxt   = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          if (LSB_FIRST != 0) shift_nxt = {rx_s, shift[7:1]};
          else                shift_nxt = {shift[6:0], rx_s};
          cnt_nxt = CNT_BIT;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            rx_data_nxt  = shift;
            rx_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push, full;

  assign pop  = rd_en && (count != '0);
  assign full = (count == CNT_FULL);
  // a same-cycle pop frees the slot, so a full FIFO can still accept the byte
  assign push = rx_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= rx_valid && full && !pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign word_rdy = (count != '0);
  assign word_out = word_rdy ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an LSB-first and an MSB-first instance share
// the serial line; FIFO output of the LSB-first instance is checked via a scoreboard.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, i_data, rd_en_l, rd_en_m;
  logic [7:0] wo_l, rxd_l, wo_m, rxd_m;
  logic       rdy_l, rv_l, fe_l, ov_l;
  logic       rdy_m, rv_m, fe_m, ov_m;
  logic [2:0] cnt_l, cnt_m;

  always #5 clk = ~clk;

  uart_rx_fifo #(.LSB_FIRST(1), .CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut_l (
    .clk(clk), .rst(rst), .i_data(i_data), .rd_en(rd_en_l),
    .word_out(wo_l), .word_rdy(rdy_l), .rx_data(rxd_l), .rx_valid(rv_l),
    .frame_err(fe_l), .overflow(ov_l), .count(cnt_l));

  uart_rx_fifo #(.LSB_FIRST(0), .CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut_m (
    .clk(clk), .rst(rst), .i_data(i_data), .rd_en(rd_en_m),
    .word_out(wo_m), .word_rdy(rdy_m), .rx_data(rxd_m), .rx_valid(rv_m),
    .frame_err(fe_m), .overflow(ov_m), .count(cnt_m));

  int         n_vec = 0;
  int         n_err = 0;
  int         nv_l = 0, nfe_l = 0, nov_l = 0;
  logic [7:0] sb [$];
  bit         saw_valid;

  always @(posedge clk) begin
    if (rv_l) nv_l++;
    if (fe_l) nfe_l++;
    if (ov_l) nov_l++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    i_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    i_data = v;
    repeat (CPB) @(negedge clk);
  endtask

  // line[0] goes out first; optionally pops the FIFO in the rx_valid cycle
  task automatic send_frame(input logic [7:0] line, input logic stop,
                            input bit pop_on_valid, output bit saw);
    logic [7:0] e;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(line[i]);
    i_data = stop;
    saw = 1'b0;
    for (int k = 0; k < CPB; k++) begin
      @(negedge clk);
      rd_en_l = 1'b0;
      if (pop_on_valid && !saw && rv_l) begin
        saw = 1'b1;
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        chk("pop_with_write", {24'h0, wo_l}, {24'h0, e});
        rd_en_l = 1'b1;
      end
    end
    @(negedge clk);
    rd_en_l = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit s;
    send_frame(b, 1'b1, 1'b0, s);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    chk(tag, {24'h0, wo_l}, {24'h0, e});
    rd_en_l = 1'b1;
    @(negedge clk);
    rd_en_l = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_data = 1'b1; rd_en_l = 1'b0; rd_en_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rxd_l, 0);
    chk("rst_word_out", wo_l, 0);
    chk("rst_word_rdy", rdy_l, 0);
    chk("rst_count", cnt_l, 0);
    rst = 1'b0;
    idle(CPB);

    // single byte
    send_byte(8'h90); sb.push_back(8'h90);
    idle(4);
    chk("b90_valid_pulses", nv_l, 1);
    chk("b90_rx_data", rxd_l, 8'h90);
    chk("b90_word_rdy", rdy_l, 1);
    chk("b90_count", cnt_l, 1);
    chk("b90_msb_view", rxd_m, 8'h09);
    pop_one("b90_word_out");
    chk("b90_drained", rdy_l, 0);

    // back-to-back bytes then ordered pops
    send_byte(8'h3C); sb.push_back(8'h3C);
    send_byte(8'h45); sb.push_back(8'h45);
    send_byte(8'h7F); sb.push_back(8'h7F);
    idle(4);
    chk("b2b_count", cnt_l, 3);
    pop_one("b2b_pop0");
    pop_one("b2b_pop1");
    pop_one("b2b_pop2");
    chk("b2b_empty_rdy", rdy_l, 0);
    chk("b2b_empty_word", wo_l, 0);

    // line sequence 1,0,0,1,0,0,0,0
    send_byte(8'h09); sb.push_back(8'h09);
    idle(4);
    chk("msb_rx_data", rxd_m, 8'h90);
    chk("lsb_rx_data", rxd_l, 8'h09);
    chk("msb_count", cnt_l, 1);

    // framing error: stop bit low
    send_frame(8'hA5, 1'b0, 1'b0, saw_valid);
    idle(2 * CPB);
    chk("ferr_pulses", nfe_l, 1);
    chk("ferr_no_valid", nv_l, 5);
    chk("ferr_count", cnt_l, 1);
    chk("ferr_rx_data", rxd_l, 8'h09);
    pop_one("ferr_pop");

    // overflow on a depth-4 FIFO
    send_byte(8'h11); sb.push_back(8'h11);
    send_byte(8'h22); sb.push_back(8'h22);
    send_byte(8'h33); sb.push_back(8'h33);
    send_byte(8'h44); sb.push_back(8'h44);
    send_byte(8'h55);
    idle(4);
    chk("ovf_count", cnt_l, 4);
    chk("ovf_pulses", nov_l, 1);
    chk("ovf_valid_pulses", nv_l, 10);

    // write and pop in the same cycle while full
    send_frame(8'h66, 1'b1, 1'b1, saw_valid); sb.push_back(8'h66);
    idle(4);
    chk("full_valid_seen", saw_valid, 1);
    chk("full_count", cnt_l, 4);
    chk("full_no_ovf", nov_l, 1);
    pop_one("full_pop0");
    pop_one("full_pop1");
    pop_one("full_pop2");
    pop_one("full_pop3");
    chk("full_drained", rdy_l, 0);

    // short glitch is not a start bit
    i_data = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    chk("glitch_valid", nv_l, 11);
    chk("glitch_ferr", nfe_l, 1);
    chk("glitch_count", cnt_l, 0);

    // reset in the middle of a byte with the FIFO occupied
    send_byte(8'h5A);
    idle(4);
    bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
    rst = 1'b1; i_data = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_rx_data", rxd_l, 0);
    chk("mid_rst_word_rdy", rdy_l, 0);
    chk("mid_rst_word_out", wo_l, 0);
    chk("mid_rst_count", cnt_l, 0);
    chk("mid_rst_strobes", {rv_l, fe_l, ov_l}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(CPB);
    send_byte(8'hC3); sb.push_back(8'hC3);
    idle(4);
    chk("post_rst_rx_data", rxd_l, 8'hC3);
    chk("post_rst_count", cnt_l, 1);
    chk("post_rst_valid", nv_l, 13);
    pop_one("post_rst_pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
